draw_line: RTL and testbench
============================

# draw_line

Bresenham line rasteriser for the GPU drawing pipeline. On a `calculate` pulse it latches two 16-bit endpoints and presents the first pixel. It then emits one pixel coordinate per `get_pixel` request until the second endpoint is reached. It sits between the command decoder, which supplies endpoints, and the pixel writer, which consumes `x_o`/`y_o` and requests the next pixel.

## Interface
- `COORD_W`, default 16: coordinate width, unsigned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `calculate`  in  1: start strobe; samples `x1`, `y1`, `x2`, `y2` on this edge.
- `x1`, `y1`  in  COORD_W: start point, unsigned.
- `x2`, `y2`  in  COORD_W: end point, unsigned.
- `get_pixel`  in  1: advance request; one step per clock it is high.
- `x_o`, `y_o`  out  COORD_W: current pixel coordinate, registered.

## Operation
- States:
  - `IDLE`: after reset; no line loaded.
  - `ACTIVE`: stepping toward the end point.
  - `DONE`: end point reached; outputs hold.
- Load happens on an edge with `calculate`=1, from any state:
  - Register `x_o`←`x1`, `y_o`←`y1`, and latch `x2`, `y2` as the target.
  - `dx` = |x2−x1|, `dy` = −|y2−y1|.
  - `sx` = +1 if x1<x2 else −1; `sy` = +1 if y1<y2 else −1.
  - `err` = dx+dy.
  - Go to `DONE` if (x1,y1)==(x2,y2), else `ACTIVE`.
- Step happens on an edge with `get_pixel`=1, state `ACTIVE`, and `calculate`=0:
  - Compute e2 = 2·err.
  - If e2 ≥ dy: err += dy and x_o += sx.
  - If e2 ≤ dx: err += dx and y_o += sy.
  - Both branches use the same e2 and are summed into err.
  - If the new (x_o,y_o) equals the target, go to `DONE`.
- `get_pixel` in `IDLE` or `DONE` is ignored; outputs hold.
- Input changes on `x1`..`y2` outside a `calculate` edge have no effect.
- Arithmetic widths:
  - dx and dy are signed COORD_W+2 bits.
  - err is signed COORD_W+3 bits; e2 is signed COORD_W+4 bits.
  - No overflow is possible for any COORD_W-bit endpoints.
- The number of steps from load to `DONE` is max(|x2−x1|, |y2−y1|). All octants, horizontal, vertical and single-point lines are supported.

## Timing
- Reset, on an edge with `reset`=1:
  - state=`IDLE`, `x_o`=0, `y_o`=0; err, dx, dy, sx, sy and target all 0.
  - Reset has priority over `calculate` and `get_pixel`.
- Reset mid-line aborts the line immediately; the next line needs a new `calculate`.
- Load latency: the first pixel (x1,y1) is on `x_o`/`y_o` in the cycle after the `calculate` edge.
- `get_pixel` may be asserted in that same cycle.
- Step latency: the new pixel is visible in the cycle after the `get_pixel` edge.
- `get_pixel` held high for N consecutive cycles produces N steps, saturating at the end point.
- `calculate` and `get_pixel` high together: load wins, no step.
- `calculate` during `ACTIVE` restarts with the new endpoints.
- Outputs are pure registers; there is no combinational path from inputs to outputs.

## Structure
- Package `draw_line_pkg` holds:
  - state enum `dl_state_e` {IDLE, ACTIVE, DONE};
  - localparams `COORD_W_DEF`=16, `ERR_W`=COORD_W+3.
- Optional combinational sub-module `bresenham_step`:
  - inputs: x, y, err, dx, dy, sx, sy;
  - outputs: next x, next y, next err.
- The top level holds the FSM, load logic and registers.

## Test plan
- **Shallow x-major negative x:** reset; load (100,90)→(50,100).
  - Output (100,90) after load; first step gives (99,90).
  - After 50 `get_pixel` pulses, output is (50,100) in `DONE`.
  - Further pulses hold (50,100).
- **Steep y-major negative y:** load (90,100)→(100,50).
  - First step gives (90,99).
  - After 50 steps, output is (100,50); x is monotonic 90→100.
- **Horizontal:** load (10,50)→(20,50).
  - Steps give (11,50)…(20,50), one per pulse.
  - `DONE` after the 10th pulse.
- **Single point:** load (10,5)→(10,5).
  - Output (10,5) and state `DONE` immediately.
  - Two `get_pixel` pulses leave (10,5) unchanged.
- **Priority and abort:**
  - `calculate` and `get_pixel` high together → loads only, no step.
  - `reset` mid-line → (0,0) in `IDLE`; `get_pixel` then has no effect.
- **Back-to-back:** `get_pixel` held high continuously after load of (0,0)→(3,7) → 7 consecutive steps ending at (3,7), then hold.

Source files
------------

// File: rtl/draw_line_pkg.sv
// Shared types and widths for the Bresenham line rasteriser.
package draw_line_pkg;

  localparam int COORD_W_DEF = 16;
  // Error accumulator width for the default coordinate width (COORD_W + 3).
  localparam int ERR_W = COORD_W_DEF + 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } dl_state_e;

endpackage

// File: rtl/draw_line_bresenham_step.sv
// One combinational Bresenham step: advances (x, y) and the error term.
module bresenham_step #(
  parameter int COORD_W = 16
) (
  input  logic        [COORD_W-1:0] i_x,
  input  logic        [COORD_W-1:0] i_y,
  input  logic signed [COORD_W+2:0] i_err,
  input  logic signed [COORD_W+1:0] i_dx,
  input  logic signed [COORD_W+1:0] i_dy,
  input  logic signed [1:0]         i_sx,
  input  logic signed [1:0]         i_sy,
  output logic        [COORD_W-1:0] o_x,
  output logic        [COORD_W-1:0] o_y,
  output logic signed [COORD_W+2:0] o_err
);

  logic signed [COORD_W+3:0] w_e2;
  logic signed [COORD_W+3:0] w_dx_e2;
  logic signed [COORD_W+3:0] w_dy_e2;
  logic signed [COORD_W+2:0] w_dx_err;
  logic signed [COORD_W+2:0] w_dy_err;
  logic        [COORD_W-1:0] w_sx_ext;
  logic        [COORD_W-1:0] w_sy_ext;
  logic                      w_move_x;
  logic                      w_move_y;

  assign w_e2     = signed'({i_err, 1'b0});
  assign w_dx_e2  = i_dx;
  assign w_dy_e2  = i_dy;
  assign w_dx_err = i_dx;
  assign w_dy_err = i_dy;
  // Direction is +1/-1; sign-extend so adding it wraps correctly as a decrement.
  assign w_sx_ext = {{(COORD_W-2){i_sx[1]}}, i_sx};
  assign w_sy_ext = {{(COORD_W-2){i_sy[1]}}, i_sy};
  assign w_move_x = (w_e2 >= w_dy_e2);
  assign w_move_y = (w_e2 <= w_dx_e2);

  always_comb begin
    o_x   = i_x;
    o_y   = i_y;
    o_err = i_err;
    if (w_move_x) begin
      o_x   = i_x + w_sx_ext;
      o_err = o_err + w_dy_err;
    end
    if (w_move_y) begin
      o_y   = i_y + w_sy_ext;
      o_err = o_err + w_dx_err;
    end
  end

endmodule

// File: rtl/draw_line.sv
// Bresenham line rasteriser: load endpoints on calculate, step on get_pixel.
module draw_line
  import draw_line_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               calculate,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic               get_pixel,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output dl_state_e          state_o
);

  localparam int ERR_WL = COORD_W + (ERR_W - COORD_W_DEF);

  dl_state_e                 r_state;
  dl_state_e                 w_next_state;
  logic        [COORD_W-1:0] r_x;
  logic        [COORD_W-1:0] r_y;
  logic        [COORD_W-1:0] r_tx;
  logic        [COORD_W-1:0] r_ty;
  logic signed [ERR_WL-1:0]  r_err;
  logic signed [COORD_W+1:0] r_dx;
  logic signed [COORD_W+1:0] r_dy;
  logic signed [1:0]         r_sx;
  logic signed [1:0]         r_sy;

  logic        [COORD_W-1:0] w_dx_mag;
  logic        [COORD_W-1:0] w_dy_mag;
  logic signed [COORD_W+1:0] w_ld_dx;
  logic signed [COORD_W+1:0] w_ld_dy;
  logic signed [ERR_WL-1:0]  w_ld_dx_e;
  logic signed [ERR_WL-1:0]  w_ld_dy_e;
  logic signed [ERR_WL-1:0]  w_ld_err;
  logic signed [1:0]         w_ld_sx;
  logic signed [1:0]         w_ld_sy;
  logic        [COORD_W-1:0] w_nx;
  logic        [COORD_W-1:0] w_ny;
  logic signed [ERR_WL-1:0]  w_nerr;
  logic                      w_step;

  assign w_dx_mag  = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
  assign w_dy_mag  = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
  assign w_ld_dx   = signed'({2'b00, w_dx_mag});
  assign w_ld_dy   = -signed'({2'b00, w_dy_mag});
  assign w_ld_dx_e = w_ld_dx;
  assign w_ld_dy_e = w_ld_dy;
  assign w_ld_err  = w_ld_dx_e + w_ld_dy_e;
  assign w_ld_sx   = (x1 < x2) ? 2'sd1 : -2'sd1;
  assign w_ld_sy   = (y1 < y2) ? 2'sd1 : -2'sd1;

  bresenham_step #(.COORD_W(COORD_W)) u_step (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_err (r_err),
    .i_dx  (r_dx),
    .i_dy  (r_dy),
    .i_sx  (r_sx),
    .i_sy  (r_sy),
    .o_x   (w_nx),
    .o_y   (w_ny),
    .o_err (w_nerr)
  );

  // Load beats step; steps are only taken while ACTIVE.
  always_comb begin
    w_next_state = r_state;
    w_step       = 1'b0;
    if (calculate) begin
      w_next_state = (x1 == x2 && y1 == y2) ? DONE : ACTIVE;
    end else if (r_state == ACTIVE && get_pixel) begin
      w_step = 1'b1;
      if (w_nx == r_tx && w_ny == r_ty) begin
        w_next_state = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_tx    <= '0;
      r_ty    <= '0;
      r_err   <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
    end else begin
      r_state <= w_next_state;
      if (calculate) begin
        r_x   <= x1;
        r_y   <= y1;
        r_tx  <= x2;
        r_ty  <= y2;
        r_dx  <= w_ld_dx;
        r_dy  <= w_ld_dy;
        r_err <= w_ld_err;
        r_sx  <= w_ld_sx;
        r_sy  <= w_ld_sy;
      end else if (w_step) begin
        r_x   <= w_nx;
        r_y   <= w_ny;
        r_err <= w_nerr;
      end
    end
  end

  assign x_o     = r_x;
  assign y_o     = r_y;
  assign state_o = r_state;

endmodule

// File: tb/tb_draw_line.sv
// Randomized and directed checks of draw_line against a precomputed pixel-path model.
module tb_draw_line;
  import draw_line_pkg::*;

  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          calculate;
  logic          get_pixel;
  logic [CW-1:0] x1, y1, x2, y2;
  logic [CW-1:0] x_o, y_o;
  dl_state_e     state_o;

  draw_line #(.COORD_W(CW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .calculate (calculate),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .get_pixel (get_pixel),
    .x_o       (x_o),
    .y_o       (y_o),
    .state_o   (state_o)
  );

  // scoreboard: remaining pixels of the current line, head = pixel on the outputs
  logic [2*CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole line rasterised up front with plain integer arithmetic.
  task automatic build_path(input int ax, input int ay, input int bx, input int by);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_q.delete();
    x = ax; y = ay;
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = -((by > ay) ? by - ay : ay - by);
    sx = (ax < bx) ? 1 : -1;
    sy = (ay < by) ? 1 : -1;
    err = dx + dy;
    exp_q.push_back({x[CW-1:0], y[CW-1:0]});
    while (!(x == bx && y == by)) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
      exp_q.push_back({x[CW-1:0], y[CW-1:0]});
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (exp_q.size() == 0) return 32'(IDLE);
    if (exp_q.size() == 1) return 32'(DONE);
    return 32'(ACTIVE);
  endfunction

  function automatic logic [31:0] exp_pix();
    if (exp_q.size() == 0) return 32'd0;
    return 32'(exp_q[0]);
  endfunction

  // driver: one clock with the given controls, then model update and compare
  task automatic tick(input bit rst, input bit calc, input bit gp,
                      input int ax, input int ay, input int bx, input int by);
    reset = rst; calculate = calc; get_pixel = gp;
    x1 = ax[CW-1:0]; y1 = ay[CW-1:0]; x2 = bx[CW-1:0]; y2 = by[CW-1:0];
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else if (calc) build_path(ax, ay, bx, by);
    else if (gp && exp_q.size() > 1) void'(exp_q.pop_front());
    check("pixel", {x_o, y_o}, exp_pix());
    check("state", 32'(state_o), exp_state());
  endtask

  task automatic load(input int ax, input int ay, input int bx, input int by, input bit gp);
    tick(1'b0, 1'b1, gp, ax, ay, bx, by);
  endtask

  // endpoints are randomized between loads; they must be ignored
  task automatic step(input bit gp);
    tick(1'b0, 1'b0, gp, $urandom_range(0, 65535), $urandom_range(0, 65535),
         $urandom_range(0, 65535), $urandom_range(0, 65535));
  endtask

  task automatic do_reset();
    tick(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 2, 3, 4);
  endtask

  function automatic int rnd_coord(input int base);
    return base + $urandom_range(0, 60);
  endfunction

  initial begin
    reset = 1'b1; calculate = 1'b0; get_pixel = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;

    do_reset();
    do_reset();
    check("reset_xy", {x_o, y_o}, 32'd0);

    // shallow x-major, negative x
    load(100, 90, 50, 100, 1'b0);
    check("load_first", {x_o, y_o}, {16'd100, 16'd90});
    step(1'b1);
    check("shallow_first_step", {x_o, y_o}, {16'd99, 16'd90});
    for (int i = 0; i < 49; i++) step(1'b1);
    check("shallow_end", {x_o, y_o}, {16'd50, 16'd100});
    check("shallow_done", 32'(state_o), 32'(DONE));
    step(1'b1);
    step(1'b1);
    check("shallow_hold", {x_o, y_o}, {16'd50, 16'd100});

    // steep y-major, negative y
    load(90, 100, 100, 50, 1'b0);
    step(1'b1);
    check("steep_first_step", {x_o, y_o}, {16'd90, 16'd99});
    for (int i = 0; i < 49; i++) begin
      logic [CW-1:0] px;
      px = x_o;
      step(1'b1);
      if (x_o < px) check("steep_x_monotonic", 32'(x_o), 32'(px));
    end
    check("steep_end", {x_o, y_o}, {16'd100, 16'd50});

    // horizontal
    load(10, 50, 20, 50, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      check("horiz_x", 32'(x_o), 32'(10 + i));
    end
    check("horiz_done", 32'(state_o), 32'(DONE));

    // single point
    load(10, 5, 10, 5, 1'b0);
    check("point_done", 32'(state_o), 32'(DONE));
    step(1'b1);
    step(1'b1);
    check("point_hold", {x_o, y_o}, {16'd10, 16'd5});

    // calculate + get_pixel together: load only
    load(10, 50, 20, 50, 1'b0);
    step(1'b1);
    load(0, 0, 5, 5, 1'b1);
    check("prio_load_only", {x_o, y_o}, 32'd0);
    check("prio_active", 32'(state_o), 32'(ACTIVE));
    step(1'b1);
    // reset mid-line
    do_reset();
    step(1'b1);
    step(1'b1);
    check("abort_idle", 32'(state_o), 32'(IDLE));
    check("abort_xy", {x_o, y_o}, 32'd0);

    // back-to-back: get_pixel held from the load cycle on
    load(0, 0, 3, 7, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1);
    check("b2b_end", {x_o, y_o}, {16'd3, 16'd7});
    for (int i = 0; i < 3; i++) step(1'b1);
    check("b2b_hold", {x_o, y_o}, {16'd3, 16'd7});

    // full-range lines: only the first steps, to exercise wide error terms
    load(0, 0, 65535, 65535, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    load(65535, 0, 0, 1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    load(3, 65535, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    load(65535, 65535, 0, 40000, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);

    // random short lines in several coordinate regions, random control traffic
    for (int n = 0; n < 48; n++) begin
      int base_x, base_y;
      base_x = (n % 4 == 0) ? 0 : (n % 4 == 1) ? 65535 - 60 : $urandom_range(0, 65000);
      base_y = (n % 3 == 0) ? 0 : (n % 3 == 1) ? 65535 - 60 : $urandom_range(0, 65000);
      load(rnd_coord(base_x), rnd_coord(base_y), rnd_coord(base_x), rnd_coord(base_y),
           $urandom_range(0, 1));
      for (int c = 0; c < 90; c++) begin
        int r;
        r = $urandom_range(0, 199);
        if (r == 0) do_reset();
        else if (r < 4)
          load(rnd_coord(base_x), rnd_coord(base_y), rnd_coord(base_x), rnd_coord(base_y),
               $urandom_range(0, 1));
        else step($urandom_range(0, 9) < 7);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
